// File: rtl/store_order_pkg.sv
// Shared types and default constants for the store ordering gate.
// Combinational pass-through paths; the backpressure policy lives in store_order_gate.
package store_order_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LD_DRAIN,
    FENCE_DRAIN
  } sog_state_e;

  localparam logic [31:0] SOG_CACHED_BASE     = 32'h8000_0000;
  localparam logic [31:0] SOG_CACHED_LEN      = 32'h4000_0000;
  localparam int unsigned SOG_MAX_OUTSTANDING = 7;

endpackage

// File: rtl/sog_region_match.sv
// Flags an address as uncached when it falls outside [BASE, BASE+LEN).
// Purely combinational; no state and no backpressure.
module sog_region_match
  import store_order_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE       = ADDR_WIDTH'(SOG_CACHED_BASE),
  parameter logic [ADDR_WIDTH-1:0] LEN        = ADDR_WIDTH'(SOG_CACHED_LEN)
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic                  uc_o
);

  // One extra bit so BASE+LEN at the top of the address space does not wrap.
  localparam logic [ADDR_WIDTH:0] LIMIT = {1'b0, BASE} + {1'b0, LEN};

  assign uc_o = (addr_i < BASE) || ({1'b0, addr_i} >= LIMIT);

endmodule

// File: rtl/store_order_gate.sv
// Orders stores ahead of uncached loads and fences; zero-latency pass-through, fence_done one cycle after drain.
// Stalls stores at MAX_OUTSTANDING or while draining; STORE_ORDER_GATE_STATS_EN adds stall_cycles_o.
module store_order_gate
  import store_order_pkg::*;
#(
  parameter int unsigned           MAX_OUTSTANDING = SOG_MAX_OUTSTANDING,
  parameter int unsigned           ADDR_WIDTH      = 32,
  parameter logic [ADDR_WIDTH-1:0] CACHED_BASE     = ADDR_WIDTH'(SOG_CACHED_BASE),
  parameter logic [ADDR_WIDTH-1:0] CACHED_LEN      = ADDR_WIDTH'(SOG_CACHED_LEN),
  localparam int unsigned          CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  st_valid_i,
  input  logic [ADDR_WIDTH-1:0] st_addr_i,
  output logic                  st_ready_o,
  output logic                  st_valid_o,
  input  logic                  st_ready_i,
  input  logic                  st_ack_i,
  input  logic                  ld_valid_i,
  input  logic [ADDR_WIDTH-1:0] ld_addr_i,
  output logic                  ld_ready_o,
  output logic                  ld_valid_o,
  input  logic                  ld_ready_i,
  input  logic                  fence_req_i,
  output logic                  fence_done_o,
  output logic [CNT_W-1:0]      outstanding_o,
  output logic                  underflow_o
`ifdef STORE_ORDER_GATE_STATS_EN
  ,
  output logic [31:0]           stall_cycles_o
`endif
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  sog_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             underflow_q, underflow_d;
  logic             fence_done_q, fence_done_d;
  logic             uc, ld_uc_req, cnt_zero, st_en, st_inc, st_dec;

  sog_region_match #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .BASE       (CACHED_BASE),
    .LEN        (CACHED_LEN)
  ) u_region (
    .addr_i (ld_addr_i),
    .uc_o   (uc)
  );

  // st_addr_i travels alongside st_valid_o on the downstream bus; only the handshake is gated here.
  assign cnt_zero   = (cnt_q == '0);
  assign ld_uc_req  = ld_valid_i & uc;
  assign st_en      = rst_ni & (state_q == IDLE) & (cnt_q < MAX_CNT) & ~ld_uc_req & ~fence_req_i;
  assign st_valid_o = st_valid_i & st_en;
  assign st_ready_o = st_ready_i & st_en;
  assign st_inc     = st_valid_o & st_ready_i;
  assign st_dec     = st_ack_i & ~cnt_zero;

  always_comb begin
    cnt_d = cnt_q;
    if (st_inc && !st_dec) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (st_dec && !st_inc) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
    underflow_d = underflow_q | (st_ack_i & cnt_zero);
  end

  always_comb begin
    state_d      = state_q;
    fence_done_d = 1'b0;
    ld_valid_o   = 1'b0;
    ld_ready_o   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fence_req_i) begin
          state_d = FENCE_DRAIN;
        end else if (ld_uc_req && !cnt_zero) begin
          state_d = LD_DRAIN;
        end else begin
          ld_valid_o = ld_valid_i;
          ld_ready_o = ld_ready_i;
        end
      end
      LD_DRAIN: begin
        // A dropped ld_valid_i means the LSU flushed the held load.
        if (!ld_valid_i) begin
          state_d = IDLE;
        end else if (cnt_zero) begin
          ld_valid_o = 1'b1;
          ld_ready_o = ld_ready_i;
          if (ld_ready_i) state_d = IDLE;
        end
      end
      FENCE_DRAIN: begin
        if (cnt_zero) begin
          fence_done_d = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!rst_ni) begin
      ld_valid_o = 1'b0;
      ld_ready_o = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      underflow_q  <= 1'b0;
      fence_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      underflow_q  <= underflow_d;
      fence_done_q <= fence_done_d;
    end
  end

  assign outstanding_o = cnt_q;
  assign underflow_o   = underflow_q;
  assign fence_done_o  = fence_done_q;

`ifdef STORE_ORDER_GATE_STATS_EN
  logic [31:0] stall_q, stall_d;
  logic        stall;

  assign stall = (st_valid_i & ~st_ready_o) | (ld_valid_i & ~ld_ready_o);

  always_comb begin
    stall_d = stall_q;
    if (stall && (stall_q != 32'hFFFF_FFFF)) stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) stall_q <= '0;
    else         stall_q <= stall_d;
  end

  assign stall_cycles_o = stall_q;
`endif

endmodule
